// File: rtl/fpu_sched_pkg.sv
// Shared types for the FPU divide/square-root scheduling logic.
package fpu_sched_pkg;

  // FP register-file address width.
  localparam int FPREG_AW = 5;

  // Divsqrt scheduler state.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } divsched_state_t;

endpackage : fpu_sched_pkg

// File: rtl/fdivsqrt_sched.sv
// Issue/writeback scheduler for the single long-latency divide/square-root
// unit. It tracks the pending destination register, stalls dependent decode
// instructions, and shares the W-stage FP write port with pipelined results.
module fdivsqrt_sched
  import fpu_sched_pkg::*;
#(
  parameter int HOLD_LIMIT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [FPREG_AW-1:0] Adr1D,
  input  logic [FPREG_AW-1:0] Adr2D,
  input  logic [FPREG_AW-1:0] Adr3D,
  input  logic                XEnD,
  input  logic                YEnD,
  input  logic                ZEnD,
  input  logic [FPREG_AW-1:0] RdD,
  input  logic                FRegWriteD,
  input  logic                DivStartE,
  input  logic [FPREG_AW-1:0] RdE,
  input  logic                FlushE,
  input  logic                DivDone,
  input  logic                DivAbort,
  input  logic                FRegWriteW,
  output logic                DivIssueE,
  output logic                DivStallE,
  output logic                FPUStallD,
  output logic                DivWriteW,
  output logic [FPREG_AW-1:0] DivRdW,
  output logic                DivBusy
);

  localparam logic [1:0] HOLD_MAX = 2'(HOLD_LIMIT);

  divsched_state_t     state;
  logic [FPREG_AW-1:0] pend_rd;
  logic [1:0]          hold_cnt;

  logic issue;
  logic write;
  logic pend_match;
  logic starve;
  logic active;

  // Hazard detection and write-port arbitration from current state and inputs.
  always_comb begin
    active     = (state != IDLE);
    issue      = (state == IDLE) & DivStartE & ~FlushE & ~DivAbort;
    write      = (state == HOLD) & ~FRegWriteW & ~DivAbort;
    pend_match = ((Adr1D == pend_rd) & XEnD) |
                 ((Adr2D == pend_rd) & YEnD) |
                 ((Adr3D == pend_rd) & ZEnD) |
                 ((RdD   == pend_rd) & FRegWriteD);
    starve     = (state == HOLD) & (hold_cnt == HOLD_MAX);
  end

  // Combinational outputs are forced low while reset is held so that no
  // input can leak a request through before the state is valid.
  always_comb begin
    DivIssueE = reset_n & issue;
    DivStallE = reset_n & DivStartE & active;
    DivWriteW = reset_n & write;
    FPUStallD = reset_n & active & (pend_match | starve);
  end

  assign DivRdW  = pend_rd;
  assign DivBusy = active;

  // Scheduler FSM: issue, wait for the unit, then wait for a free write slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pend_rd  <= '0;
      hold_cnt <= '0;
    end else if (DivAbort) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            pend_rd <= RdE;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (DivDone) begin
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (write) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 2'd1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule : fdivsqrt_sched

// File: tb/tb_fdivsqrt_sched.sv
// Directed self-checking bench for fdivsqrt_sched.
module tb_fdivsqrt_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Adr1D, Adr2D, Adr3D, RdD, RdE;
  logic       XEnD, YEnD, ZEnD, FRegWriteD;
  logic       DivStartE, FlushE, DivDone, DivAbort, FRegWriteW;
  logic       DivIssueE, DivStallE, FPUStallD, DivWriteW, DivBusy;
  logic [4:0] DivRdW;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  fdivsqrt_sched #(.HOLD_LIMIT(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Adr1D      (Adr1D),
    .Adr2D      (Adr2D),
    .Adr3D      (Adr3D),
    .XEnD       (XEnD),
    .YEnD       (YEnD),
    .ZEnD       (ZEnD),
    .RdD        (RdD),
    .FRegWriteD (FRegWriteD),
    .DivStartE  (DivStartE),
    .RdE        (RdE),
    .FlushE     (FlushE),
    .DivDone    (DivDone),
    .DivAbort   (DivAbort),
    .FRegWriteW (FRegWriteW),
    .DivIssueE  (DivIssueE),
    .DivStallE  (DivStallE),
    .FPUStallD  (FPUStallD),
    .DivWriteW  (DivWriteW),
    .DivRdW     (DivRdW),
    .DivBusy    (DivBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    Adr1D = '0; Adr2D = '0; Adr3D = '0; RdD = '0; RdE = '0;
    XEnD = 0; YEnD = 0; ZEnD = 0; FRegWriteD = 0;
    DivStartE = 0; FlushE = 0; DivDone = 0; DivAbort = 0; FRegWriteW = 0;
  endtask

  initial begin
    quiet();
    reset_n = 0;
    #1;
    chk("rst_busy", 8'(DivBusy), 8'd0);
    chk("rst_rdw", 8'(DivRdW), 8'd0);
    tick(); tick();
    reset_n = 1;
    tick();

    // Issue RdE=5; a source of 5 must not stall in the issue cycle.
    DivStartE = 1; RdE = 5'd5; Adr1D = 5'd5; XEnD = 1;
    #1;
    chk("issue", 8'(DivIssueE), 8'd1);
    chk("issue_nostallD", 8'(FPUStallD), 8'd0);
    chk("issue_nostallE", 8'(DivStallE), 8'd0);
    chk("issue_busy0", 8'(DivBusy), 8'd0);
    tick();
    quiet();
    #1;
    chk("busy1", 8'(DivBusy), 8'd1);
    chk("rdw5", 8'(DivRdW), 8'd5);

    // Pending-match stalls while BUSY.
    Adr2D = 5'd5; YEnD = 1; #1;
    chk("match_y", 8'(FPUStallD), 8'd1);
    YEnD = 0; #1;
    chk("match_y_dis", 8'(FPUStallD), 8'd0);
    RdD = 5'd5; FRegWriteD = 1; #1;
    chk("match_waw", 8'(FPUStallD), 8'd1);
    FRegWriteD = 0; Adr3D = 5'd6; ZEnD = 1; #1;
    chk("nomatch_z", 8'(FPUStallD), 8'd0);
    quiet();

    // Second start while busy is stalled.
    DivStartE = 1; RdE = 5'd0; #1;
    chk("busy_stallE", 8'(DivStallE), 8'd1);
    chk("busy_noissue", 8'(DivIssueE), 8'd0);
    for (int i = 0; i < 8; i++) tick();

    // DivDone with a free port: write one cycle later.
    DivDone = 1; #1;
    chk("done_nowrite", 8'(DivWriteW), 8'd0);
    tick();
    DivDone = 0; Adr1D = 5'd5; XEnD = 1; #1;
    chk("write", 8'(DivWriteW), 8'd1);
    chk("write_rd", 8'(DivRdW), 8'd5);
    chk("write_match", 8'(FPUStallD), 8'd1);
    chk("write_stallE", 8'(DivStallE), 8'd1);
    chk("write_noissue", 8'(DivIssueE), 8'd0);
    tick();
    #1;
    chk("post_busy0", 8'(DivBusy), 8'd0);
    chk("post_nostall", 8'(FPUStallD), 8'd0);
    chk("post_issue", 8'(DivIssueE), 8'd1);
    tick();
    quiet();

    // Register 0 is an ordinary destination.
    Adr3D = 5'd0; ZEnD = 1; #1;
    chk("r0_busy", 8'(DivBusy), 8'd1);
    chk("r0_match", 8'(FPUStallD), 8'd1);
    quiet();

    // Starvation: port held by pipelined results.
    DivDone = 1; FRegWriteW = 1;
    tick();
    DivDone = 0; #1;
    chk("hold1_nowrite", 8'(DivWriteW), 8'd0);
    chk("hold1_nostall", 8'(FPUStallD), 8'd0);
    tick(); #1;
    chk("hold2_nostall", 8'(FPUStallD), 8'd0);
    tick(); #1;
    chk("hold3_starve", 8'(FPUStallD), 8'd1);
    chk("hold3_nowrite", 8'(DivWriteW), 8'd0);
    tick(); #1;
    chk("hold4_starve", 8'(FPUStallD), 8'd1);
    FRegWriteW = 0; #1;
    chk("hold_write", 8'(DivWriteW), 8'd1);
    chk("hold_write_stall", 8'(FPUStallD), 8'd1);
    chk("hold_write_rd", 8'(DivRdW), 8'd0);
    tick(); #1;
    chk("starve_release", 8'(FPUStallD), 8'd0);
    chk("starve_idle", 8'(DivBusy), 8'd0);
    chk("starve_nowrite", 8'(DivWriteW), 8'd0);

    // Abort coincident with DivDone.
    DivStartE = 1; RdE = 5'd7;
    tick();
    DivStartE = 0; DivDone = 1; DivAbort = 1; #1;
    chk("abort_rd7", 8'(DivRdW), 8'd7);
    chk("abort_nowrite", 8'(DivWriteW), 8'd0);
    tick();
    quiet(); #1;
    chk("abort_idle", 8'(DivBusy), 8'd0);
    chk("abort_nowrite2", 8'(DivWriteW), 8'd0);

    // Flushed start does not issue.
    DivStartE = 1; FlushE = 1; RdE = 5'd3; #1;
    chk("flush_noissue", 8'(DivIssueE), 8'd0);
    tick();
    quiet(); #1;
    chk("flush_idle", 8'(DivBusy), 8'd0);

    // Abort in HOLD suppresses the write.
    DivStartE = 1; RdE = 5'd8;
    tick();
    DivStartE = 0; DivDone = 1;
    tick();
    DivDone = 0; DivAbort = 1; #1;
    chk("holdabort_nowrite", 8'(DivWriteW), 8'd0);
    tick();
    quiet(); #1;
    chk("holdabort_idle", 8'(DivBusy), 8'd0);
    chk("holdabort_nowrite2", 8'(DivWriteW), 8'd0);

    // Reset pulsed while in HOLD.
    DivStartE = 1; RdE = 5'd9;
    tick();
    DivStartE = 0; DivDone = 1;
    tick();
    DivDone = 0; FRegWriteW = 1; Adr1D = 5'd9; XEnD = 1; DivStartE = 1; #1;
    chk("prerst_stall", 8'(FPUStallD), 8'd1);
    chk("prerst_stallE", 8'(DivStallE), 8'd1);
    reset_n = 0; #1;
    chk("rst_issue", 8'(DivIssueE), 8'd0);
    chk("rst_stallE", 8'(DivStallE), 8'd0);
    chk("rst_stallD", 8'(FPUStallD), 8'd0);
    chk("rst_write", 8'(DivWriteW), 8'd0);
    chk("rst_busy2", 8'(DivBusy), 8'd0);
    chk("rst_rdw2", 8'(DivRdW), 8'd0);
    tick();
    quiet();
    reset_n = 1;
    tick(); #1;
    chk("after_rst_busy", 8'(DivBusy), 8'd0);
    chk("after_rst_write", 8'(DivWriteW), 8'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_fdivsqrt_sched

// File: doc/fdivsqrt_sched.md
# fdivsqrt_sched

Issue and writeback scheduler for the FPU's single long-latency divide/square-root unit. It accepts one divsqrt operation from the execute stage and tracks its destination FP register while the unit iterates. It stalls decode-stage instructions that read or overwrite that register (RAW/WAW). It shares the W-stage FP register-file write port between the pipelined FPU result and the divsqrt result, with pipelined results taking priority. It sits beside the FPU forwarding/stall logic, and its FPUStallD is ORed with the existing decode stall.

## Interface
Parameters:
- HOLD_LIMIT, 2: number of consecutive HOLD cycles without a free write port before a decode bubble is forced.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- Adr1D, Adr2D, Adr3D  in  5 each  decode-stage source register addresses
- XEnD, YEnD, ZEnD  in  1 each  corresponding source is used
- RdD  in  5  decode-stage destination
- FRegWriteD  in  1  decode instruction writes the FP register file
- DivStartE  in  1  valid divsqrt in execute requesting issue
- RdE  in  5  execute-stage destination
- FlushE  in  1  execute instruction squashed
- DivDone  in  1  unit result valid (single-cycle pulse)
- DivAbort  in  1  kill any outstanding operation (trap/flush)
- FRegWriteW  in  1  pipelined result owns the write port this cycle
- DivIssueE  out  1  start pulse to the divsqrt unit
- DivStallE  out  1  hold execute; unit occupied
- FPUStallD  out  1  stall decode
- DivWriteW  out  1  write divsqrt result into the register file this cycle
- DivRdW  out  5  register address for DivWriteW
- DivBusy  out  1  state is not IDLE

## Operation
- States: IDLE, BUSY, HOLD. The destination register is kept in PendRd[4:0]. HoldCnt[1:0] saturates at HOLD_LIMIT.
- IDLE:
  - DivIssueE = DivStartE & ~FlushE & ~DivAbort.
  - On issue: PendRd <= RdE and go to BUSY.
- BUSY:
  - DivDone -> HOLD with HoldCnt = 0.
  - DivStartE asserts DivStallE.
- HOLD:
  - DivWriteW = ~FRegWriteW.
  - When DivWriteW = 1: go to IDLE next cycle.
  - Otherwise: HoldCnt increments, saturating.
- DivStallE = DivStartE & (state != IDLE). No new issue happens until the cycle after the result is written.
- FPUStallD = (state != IDLE) & (PendMatch | Starve).
  - PendMatch = ((Adr1D == PendRd) & XEnD) | ((Adr2D == PendRd) & YEnD) | ((Adr3D == PendRd) & ZEnD) | ((RdD == PendRd) & FRegWriteD).
  - Starve = (state == HOLD) & (HoldCnt == HOLD_LIMIT). This forces a bubble so that a free write slot reaches W.
- DivRdW = PendRd at all times.
- DivAbort in any state: IDLE next cycle and no write.
  - DivAbort with DivDone in the same cycle: abort wins.
  - In HOLD, DivAbort also suppresses DivWriteW that cycle.
- Every register address, including register 0, is an ordinary FP register. There is no exclusion.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, PendRd 0, HoldCnt 0. All outputs are 0 while in reset.
- DivIssueE, DivStallE, DivWriteW and FPUStallD are combinational from inputs and state. DivBusy and DivRdW are purely registered.
- Issue cycle t (IDLE):
  - No pending-match stall at t. The decode/execute hazard for RdE is covered by the existing E-stage stall.
  - DivBusy = 1 from t+1.
- DivDone at cycle t: HOLD at t+1. Earliest DivWriteW is t+1.
- Pending match remains active through the DivWriteW cycle inclusive and drops the following cycle. Decode never reads a stale value.
- Maximum write delay after entering HOLD is HOLD_LIMIT + 3 cycles: the bubble must travel D→E→M→W.
- DivStartE in the write cycle is stalled. It issues the next cycle.
- Reset asserted mid-operation discards the operation without a write.

## Structure
- Shared package fpu_sched_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, HOLD} divsched_state_t
  - localparam FPREG_AW = 5
- Single module. The comparator logic is small and needs no sub-module.

## Test plan
- Issue RdE=5 in IDLE; DivDone 10 cycles later with FRegWriteW=0 -> DivWriteW=1 and DivRdW=5 one cycle after DivDone; DivBusy=0 the next cycle.
- While BUSY with PendRd=5: Adr2D=5 with YEnD=1 -> FPUStallD=1. Same address with YEnD=0 -> 0. RdD=5 with FRegWriteD=1 -> 1.
- In HOLD with FRegWriteW held at 1 -> DivWriteW=0, FPUStallD=1 from the third HOLD cycle. Drop FRegWriteW -> write occurs and the stall releases the cycle after.
- Second DivStartE while BUSY -> DivStallE=1 and DivIssueE=0 until the write cycle; DivIssueE=1 the cycle after the write.
- DivAbort coincident with DivDone -> IDLE next cycle, DivWriteW never asserted. DivStartE with FlushE=1 -> no issue.
- reset_n pulsed low while in HOLD -> all outputs 0 immediately; IDLE and no write after release.
